serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
//  Parallel-in, serial-out frame transmitter; the sending end of the lab's serial link.
//  Accepts one DATA_W-bit word per valid/ready handshake and shifts it out on txd as a frame.
//  Frame order: start bit (0), data LSB first, optional even parity bit, stop bit (1).
//  Sits between a parallel producer (counter, register file, switch input) and the serial line.
// PARAMETERS
//  DATA_W        8  data bits per frame, >=1
//  CLKS_PER_BIT  4  clk cycles each bit is held on txd, >=1
//  PARITY_EN     1  1: insert even-parity bit after data; 0: no parity bit
// PORTS
//  clk       in   1       all state updates on rising edge
//  rst       in   1       asynchronous, active-high reset
//  tx_valid  in   1       producer has a word on tx_data
//  tx_data   in   DATA_W  word to send; sampled only at handshake
//  tx_ready  out  1       transmitter idle, can accept a word
//  txd       out  1       serial line, idles high
//  busy      out  1       frame in progress (START..STOP)
//  done      out  1       one-cycle pulse, frame completed
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, txd=1, tx_ready=1, busy=0, done=0; counters and shift reg cleared.
//  - rst mid-frame: aborts the frame; txd=1 at once; no done pulse; the word is lost.
//  - All outputs are registered or decoded from registered state; no input-to-output combinational path.
//  - Handshake: accept when tx_valid && tx_ready at a rising edge. tx_data latched into shift reg.
//    Parity = ^tx_data, latched at the same edge.
//  - tx_ready=1 only in IDLE. tx_data/tx_valid changes while busy are ignored.
//  - FSM states:
//    IDLE -> START on handshake.
//    START -> DATA after CLKS_PER_BIT cycles.
//    DATA -> PARITY (PARITY_EN=1) or STOP (PARITY_EN=0) after DATA_W bits.
//    PARITY -> STOP after CLKS_PER_BIT cycles.
//    STOP -> IDLE after CLKS_PER_BIT cycles.
//  - txd per state: IDLE 1, START 0, DATA shift_reg[0] (shift right at each bit boundary),
//    PARITY latched parity, STOP 1.
//  - Timing: handshake at edge k -> txd=0 from edge k.
//    Each bit occupies exactly CLKS_PER_BIT cycles.
//    Frame length F = (2+DATA_W+PARITY_EN)*CLKS_PER_BIT cycles.
//  - busy=1 from edge k to edge k+F. At edge k+F: state=IDLE, busy=0, tx_ready=1, done=1 for that one cycle.
//  - Back-to-back: the earliest next handshake is edge k+F+1, so one idle (txd=1) cycle separates frames.
//  - Bit-cycle counter: width clog2(CLKS_PER_BIT), wraps 0..CLKS_PER_BIT-1.
//    Bit index counter: width clog2(DATA_W+1). No other arithmetic.
//  - CLKS_PER_BIT=1: a bit changes every cycle; same state sequence; no special case.
// TESTING
//  1. Assert rst mid-sim with tx_valid=1 -> txd=1, tx_ready=1, busy=0, done=0 within the same cycle;
//     no handshake while rst=1.
//  2. DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=1; send 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,0,1.
//     Each bit is 4 cycles; 44 cycles total; done pulses once at cycle 44.
//  3. Send 0x07, PARITY_EN=1 -> parity bit=1.
//     Same bench with PARITY_EN=0 -> 40-cycle frame, no parity slot.
//  4. Hold tx_valid=1 with 0x3C then 0xC3 -> two frames separated by exactly one idle-high cycle.
//     tx_ready=1 only on the done cycle between them.
//  5. Change tx_data every cycle during a frame of 0x5A -> serialized bits still 0x5A; no extra handshake.
//  6. Assert rst at bit 3 of a frame, then release and send 0xFF -> first frame truncated, no done;
//     clean 0xFF frame follows (parity 0).

Source files
------------

// File: rtl/serial_frame_tx_if.sv
// Handshake and serial-line bundle between a parallel producer and serial_frame_tx.
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              txd;
  logic              busy;
  logic              done;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, txd, busy, done
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, txd, busy, done
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, data LSB first,
// optional even parity, stop bit; each bit held for CLKS_PER_BIT cycles.
//
// state    | meaning
// S_IDLE   | line high, ready to accept a word
// S_START  | driving start bit (0)
// S_DATA   | driving shift_q[0], shifting right at each bit boundary
// S_PARITY | driving latched even parity
// S_STOP   | driving stop bit (1); done pulses on the way back to idle
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic               clk,
  input  logic               rst,
  serial_frame_tx_if.slave   tx_if
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              done_q, done_d;
  logic              bit_end;
  logic              txd_w;

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    // The bit-cycle counter free-runs in every non-idle state and wraps at CNT_LAST.
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (tx_if.tx_valid) begin
          state_d = S_START;
          shift_d = tx_if.tx_data;
          par_d   = ^tx_if.tx_data;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    txd_w = 1'b1;
    unique case (state_q)
      S_IDLE:   txd_w = 1'b1;
      S_START:  txd_w = 1'b0;
      S_DATA:   txd_w = shift_q[0];
      S_PARITY: txd_w = par_q;
      S_STOP:   txd_w = 1'b1;
      default:  txd_w = 1'b1;
    endcase
  end

  assign tx_if.txd      = txd_w;
  assign tx_if.tx_ready = (state_q == S_IDLE);
  assign tx_if.busy     = (state_q != S_IDLE);
  assign tx_if.done     = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: one parity instance, one no-parity instance.
module tb_serial_frame_tx;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  serial_frame_tx_if #(.DATA_W(8)) bus ();
  serial_frame_tx_if #(.DATA_W(8)) bus_np ();

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .tx_if (bus.slave)
  );

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut_np (
    .clk   (clk),
    .rst   (rst),
    .tx_if (bus_np.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] d, input bit np);
    @(negedge clk);
    if (np) begin
      bus_np.tx_valid = 1'b1;
      bus_np.tx_data  = d;
    end else begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = d;
    end
    @(negedge clk);
    bus.tx_valid    = 1'b0;
    bus_np.tx_valid = 1'b0;
  endtask

  // Entered at the falling edge right after the accepting rising edge.
  // mode 0: idle producer; 1: scramble tx_data with valid high; 2: hold valid with nxt.
  task automatic run_frame(input logic [7:0] d, input bit np, input int mode, input logic [7:0] nxt);
    logic [10:0] bits;
    int          nb;
    bits = np ? {1'b1, 1'b1, d, 1'b0} : {1'b1, ^d, d, 1'b0};
    nb   = np ? 10 : 11;
    for (int c = 0; c < nb * 4; c++) begin
      chk($sformatf("txd[%0d] of %0h", c, d), np ? bus_np.txd : bus.txd, bits[c / 4]);
      chk($sformatf("busy[%0d]", c), np ? bus_np.busy : bus.busy, 1);
      chk($sformatf("ready[%0d]", c), np ? bus_np.tx_ready : bus.tx_ready, 0);
      chk($sformatf("done[%0d]", c), np ? bus_np.done : bus.done, 0);
      if (mode == 1) begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'($urandom);
      end else if (mode == 2) begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = nxt;
      end
      @(negedge clk);
    end
    chk("done_pulse", np ? bus_np.done : bus.done, 1);
    chk("busy_end", np ? bus_np.busy : bus.busy, 0);
    chk("ready_end", np ? bus_np.tx_ready : bus.tx_ready, 1);
    chk("txd_end", np ? bus_np.txd : bus.txd, 1);
    if (mode == 1) bus.tx_valid = 1'b0;
    @(negedge clk);
    chk("done_after", np ? bus_np.done : bus.done, 0);
    chk("ready_after", np ? bus_np.tx_ready : bus.tx_ready, (mode == 2) ? 0 : 1);
    chk("txd_after", np ? bus_np.txd : bus.txd, (mode == 2) ? 0 : 1);
  endtask

  initial begin
    rst             = 1'b1;
    bus.tx_valid    = 1'b0;
    bus.tx_data     = '0;
    bus_np.tx_valid = 1'b0;
    bus_np.tx_data  = '0;

    @(posedge clk);
    #1;
    chk("rst_txd", bus.txd, 1);
    chk("rst_ready", bus.tx_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;

    start_frame(8'hA5, 0);
    run_frame(8'hA5, 0, 0, 8'h00);

    start_frame(8'h07, 0);
    run_frame(8'h07, 0, 0, 8'h00);

    start_frame(8'h07, 1);
    run_frame(8'h07, 1, 0, 8'h00);

    start_frame(8'h3C, 0);
    run_frame(8'h3C, 0, 2, 8'hC3);
    bus.tx_valid = 1'b0;
    run_frame(8'hC3, 0, 0, 8'h00);

    start_frame(8'h5A, 0);
    run_frame(8'h5A, 0, 1, 8'h00);

    // Abort a frame of 0x81 while data bit 2 (a 0) is on the line.
    start_frame(8'h81, 0);
    repeat (14) @(negedge clk);
    chk("pre_abort_txd", bus.txd, 0);
    #2;
    rst          = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    #1;
    chk("abort_txd", bus.txd, 1);
    chk("abort_ready", bus.tx_ready, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold_busy", bus.busy, 0);
      chk("rst_hold_ready", bus.tx_ready, 1);
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
    rst          = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_done", bus.done, 0);
      chk("post_abort_txd", bus.txd, 1);
      chk("post_abort_busy", bus.busy, 0);
    end

    start_frame(8'hFF, 0);
    run_frame(8'hFF, 0, 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
